uart_cmd_engine: RTL and testbench
==================================

// Module: uart_cmd_engine
// PURPOSE
//  Parametrised command engine between the UART core's RX frame bus and a block coprocessor (e.g. AES).
//  Frame = header opcode byte, PAYLOAD_BYTES of data, trailer byte.
//  Validates frames, writes NUM_SLOTS operand registers, starts the coprocessor, and captures its result under a watchdog.
//  Returns read/status frames over a valid/ready TX handshake. Sits between uart_top and the coprocessor in top.
// PARAMETERS
//  PAYLOAD_BYTES   16     data bytes per frame; FRAME_BYTES = PAYLOAD_BYTES+2 (derived localparam)
//  NUM_SLOTS       2      operand registers, 1..8 (slot0 = key, slot1 = text for AES)
//  TIMEOUT_CYCLES  4096   max clk cycles from cop_start to cop_done, >=2
// PORTS
//  clk          in   1                          single clock, all logic on posedge
//  reset        in   1                          synchronous, active-high
//  frame_valid  in   1                          1-cycle strobe: frame_data holds a complete RX frame
//  frame_data   in   FRAME_BYTES*8              header [top byte], payload, trailer [7:0]
//  tx_valid     out  1                          response frame pending
//  tx_ready     in   1                          UART accepts tx_data this cycle
//  tx_data      out  FRAME_BYTES*8              response frame, same layout as RX
//  slots_out    out  NUM_SLOTS*PAYLOAD_BYTES*8  slot n at [n*P*8 +: P*8], P = PAYLOAD_BYTES
//  cop_start    out  1                          1-cycle start pulse to coprocessor
//  cop_done     in   1                          coprocessor result valid strobe
//  cop_result   in   PAYLOAD_BYTES*8            coprocessor output
//  busy         out  1                          coprocessor run in progress
//  err_any      out  1                          OR of sticky error flags
// BEHAVIOUR
//  Reset: all outputs 0, slots/result/counters/flags 0, FSM IDLE. Any in-flight run or pending TX is abandoned.
//  FSM IDLE -> DEC -> (RESP | IDLE); RESP -> IDLE on tx_valid&tx_ready.
//  IDLE: frame_valid latches frame_data, frame_cnt++ (8b wrap).
//    frame_valid outside IDLE: frame dropped, err_overrun set, drop_cnt++ (8b saturating).
//  DEC (t+1 after strobe): check header/trailer.
//    Fail: err_frame set, no response, -> IDLE.
//    Opcodes (header byte):
//    'p'+n  write payload to slot n (n<NUM_SLOTS). Visible on slots_out at t+2. No response.
//    'P'+n  read slot n -> response.
//    'E'    start. If !busy: cop_start=1 at t+2, busy=1. If busy: err_busy set, no start. No response.
//    '@'    read result register -> response.
//    'A'    ping: payload "123456789012345678" truncated to PAYLOAD_BYTES -> response.
//    '?'    status -> response. Clears all sticky errors and drop_cnt in the same cycle the response is built.
//    Other opcode, or slot n>=NUM_SLOTS: err_frame set, no response.
//  Status payload: byte0 = {2'b0,busy,err_overrun,err_busy,err_timeout,err_frame,result_valid};
//    byte1 = drop_cnt; byte2 = frame_cnt; rest 0.
//  Response: tx_valid rises at t+2. tx_data held stable until tx_ready.
//    Header echoes opcode; trailer per CONFIGURATION.
//  Run: timeout counter clears on cop_start and counts while busy.
//    cop_done while busy: result <= cop_result, result_valid=1, busy=0.
//    Counter reaching TIMEOUT_CYCLES-1 without done: err_timeout set, busy=0, result unchanged.
//    Done and timeout in the same cycle: done wins. cop_done while !busy: ignored.
//  A new 'E' clears result_valid on start.
//  Slot writes during busy are allowed; the coprocessor samples operands on cop_start only.
// CONFIGURATION
//  UART_CMD_CHECKSUM_EN defined: trailer must equal XOR of header and all payload bytes; TX trailer generated the same way.
//  Undefined: trailer must equal header (legacy framing); TX trailer = header.
// STRUCTURE
//  Package uart_cmd_pkg: opcode constants (OP_WR_BASE, OP_RD_BASE, OP_START, OP_RESULT, OP_PING, OP_STATUS),
//    FSM state encodings, status bit indices.
//  Sub-module uart_cmd_frame_check: combinational trailer check for RX and trailer generation for TX;
//    owns the UART_CMD_CHECKSUM_EN switch. One instance each for RX and TX.
// TESTING
//  Write/read: 'p' frame with payload 00..0F, then 'P' frame -> tx_data payload 00..0F, header 'P'; slot0 on slots_out at t+2.
//  Bad frame: header 'p', trailer mismatch -> no tx_valid, slot unchanged; '?' -> byte0 bit1=1; second '?' -> byte0 bit1=0.
//  Run: load slots, 'E'; model asserts cop_done 11 cycles later with result 0x3925841D...;
//    '@' -> that value, status result_valid=1.
//  Timeout: TIMEOUT_CYCLES=16, no cop_done -> busy falls 16 cycles after cop_start, err_timeout=1, err_any=1.
//  Backpressure: hold tx_ready=0 for 50 cycles, strobe 3 frames -> tx_data stable, drop_cnt=3, err_overrun=1.
//  Reset mid-run and with tx_valid high -> next cycle all outputs 0; a later cop_done leaves result_valid=0.
//    Repeat the bench with UART_CMD_CHECKSUM_EN defined.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// ----------------------------------------------------------------------------
// uart_cmd_pkg: opcodes, FSM states and status bit indices for uart_cmd_engine
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_cmd_pkg;

  localparam logic [7:0] OP_WR_BASE = 8'h70;  // 'p' + slot
  localparam logic [7:0] OP_RD_BASE = 8'h50;  // 'P' + slot
  localparam logic [7:0] OP_START   = 8'h45;  // 'E'
  localparam logic [7:0] OP_RESULT  = 8'h40;  // '@'
  localparam logic [7:0] OP_PING    = 8'h41;  // 'A'
  localparam logic [7:0] OP_STATUS  = 8'h3F;  // '?'

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEC  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int STAT_RESULT_VALID = 0;
  localparam int STAT_ERR_FRAME    = 1;
  localparam int STAT_ERR_TIMEOUT  = 2;
  localparam int STAT_ERR_BUSY     = 3;
  localparam int STAT_ERR_OVERRUN  = 4;
  localparam int STAT_BUSY         = 5;

  // Byte i of the ping string "123456789012345678", zero beyond its end
  function automatic logic [7:0] ping_byte(input int i);
    if (i < 18) return 8'h30 + 8'(((i % 10) + 1) % 10);
    else        return 8'h00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_cmd_frame_check.sv
// ----------------------------------------------------------------------------
// uart_cmd_frame_check: trailer generation/check; UART_CMD_CHECKSUM_EN selects XOR trailer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_cmd_frame_check #(
  parameter int PAYLOAD_BYTES = 16
) (
  input  logic [(PAYLOAD_BYTES+1)*8-1:0] body,
  input  logic [7:0]                     trailer_in,
  output logic [7:0]                     trailer_gen,
  output logic                           trailer_ok
);

`ifdef UART_CMD_CHECKSUM_EN
  always_comb begin
    trailer_gen = 8'h00;
    for (int i = 0; i < PAYLOAD_BYTES + 1; i++) begin
      trailer_gen = trailer_gen ^ body[i*8 +: 8];
    end
  end
`else
  // Legacy framing repeats the header; payload does not contribute
  logic w_payload_unused;
  assign w_payload_unused = ^body[PAYLOAD_BYTES*8-1:0];
  assign trailer_gen      = body[PAYLOAD_BYTES*8 +: 8];
`endif

  assign trailer_ok = (trailer_in == trailer_gen);

endmodule

`default_nettype wire

// File: rtl/uart_cmd_engine.sv
// ----------------------------------------------------------------------------
// uart_cmd_engine: RX frame decoder, operand slots, coprocessor run/watchdog, TX responses
// Rev 1.0   (UART_CMD_CHECKSUM_EN selects XOR trailers, otherwise trailer = header)
// ----------------------------------------------------------------------------
`default_nettype none

module uart_cmd_engine
  import uart_cmd_pkg::*;
#(
  parameter int PAYLOAD_BYTES  = 16,
  parameter int NUM_SLOTS      = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                frame_valid,
  input  logic [(PAYLOAD_BYTES+2)*8-1:0]      frame_data,
  output logic                                tx_valid,
  input  logic                                tx_ready,
  output logic [(PAYLOAD_BYTES+2)*8-1:0]      tx_data,
  output logic [NUM_SLOTS*PAYLOAD_BYTES*8-1:0] slots_out,
  output logic                                cop_start,
  input  logic                                cop_done,
  input  logic [PAYLOAD_BYTES*8-1:0]          cop_result,
  output logic                                busy,
  output logic                                err_any
);

  localparam int FRAME_BYTES = PAYLOAD_BYTES + 2;
  localparam int PB          = PAYLOAD_BYTES * 8;
  localparam int FB          = FRAME_BYTES * 8;
  localparam int CW          = $clog2(TIMEOUT_CYCLES);

  state_t                r_state, w_next;
  logic [FB-1:0]         r_frame;
  logic [NUM_SLOTS*PB-1:0] r_slots;
  logic [PB-1:0]         r_result;
  logic                  r_result_valid, r_busy, r_cop_start;
  logic [CW-1:0]         r_cnt;
  logic                  r_err_frame, r_err_timeout, r_err_busy, r_err_overrun;
  logic [7:0]            r_drop_cnt, r_frame_cnt;
  logic                  r_tx_valid;
  logic [FB-1:0]         r_tx_data;

  logic [7:0]    w_header;
  logic [PB-1:0] w_payload;
  logic [2:0]    w_slot_idx;
  logic          w_slot_ok, w_is_wr, w_is_rd, w_rx_ok;
  logic          w_wr_en, w_start_en, w_busy_err, w_frame_err, w_resp_en, w_status_clr, w_drop;
  logic [PB-1:0] w_resp_payload, w_ping, w_status;
  logic [7:0]    w_stat0, w_tx_trailer;
  logic          w_tx_chk_unused;

  assign w_header   = r_frame[FB-1 -: 8];
  assign w_payload  = r_frame[8 +: PB];
  assign w_slot_idx = w_header[2:0];
  assign w_slot_ok  = ({1'b0, w_slot_idx} < 4'(NUM_SLOTS));
  assign w_is_wr    = (w_header[7:3] == OP_WR_BASE[7:3]) && w_slot_ok;
  assign w_is_rd    = (w_header[7:3] == OP_RD_BASE[7:3]) && w_slot_ok;
  assign w_drop     = frame_valid && (r_state != ST_IDLE);

  uart_cmd_frame_check #(.PAYLOAD_BYTES(PAYLOAD_BYTES)) u_rx_check (
    .body        (r_frame[FB-1:8]),
    .trailer_in  (r_frame[7:0]),
    .trailer_gen (),
    .trailer_ok  (w_rx_ok)
  );

  uart_cmd_frame_check #(.PAYLOAD_BYTES(PAYLOAD_BYTES)) u_tx_gen (
    .body        ({w_header, w_resp_payload}),
    .trailer_in  (8'h00),
    .trailer_gen (w_tx_trailer),
    .trailer_ok  (w_tx_chk_unused)
  );

  always_comb begin
    w_ping = '0;
    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
      w_ping[(PAYLOAD_BYTES-1-i)*8 +: 8] = ping_byte(i);
    end
  end

  always_comb begin
    w_stat0                    = '0;
    w_stat0[STAT_RESULT_VALID] = r_result_valid;
    w_stat0[STAT_ERR_FRAME]    = r_err_frame;
    w_stat0[STAT_ERR_TIMEOUT]  = r_err_timeout;
    w_stat0[STAT_ERR_BUSY]     = r_err_busy;
    w_stat0[STAT_ERR_OVERRUN]  = r_err_overrun;
    w_stat0[STAT_BUSY]         = r_busy;
    w_status                   = '0;
    w_status[PB-1  -: 8]       = w_stat0;
    w_status[PB-9  -: 8]       = r_drop_cnt;
    w_status[PB-17 -: 8]       = r_frame_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    w_wr_en        = 1'b0;
    w_start_en     = 1'b0;
    w_busy_err     = 1'b0;
    w_frame_err    = 1'b0;
    w_resp_en      = 1'b0;
    w_status_clr   = 1'b0;
    w_resp_payload = '0;
    case (r_state)
      ST_IDLE: if (frame_valid) w_next = ST_DEC;
      ST_DEC: begin
        if (!w_rx_ok) begin
          w_frame_err = 1'b1;
        end else if (w_is_wr) begin
          w_wr_en = 1'b1;
        end else if (w_is_rd) begin
          w_resp_en      = 1'b1;
          w_resp_payload = r_slots[int'(w_slot_idx)*PB +: PB];
        end else if (w_header == OP_START) begin
          if (r_busy) w_busy_err = 1'b1;
          else        w_start_en = 1'b1;
        end else if (w_header == OP_RESULT) begin
          w_resp_en      = 1'b1;
          w_resp_payload = r_result;
        end else if (w_header == OP_PING) begin
          w_resp_en      = 1'b1;
          w_resp_payload = w_ping;
        end else if (w_header == OP_STATUS) begin
          w_resp_en      = 1'b1;
          w_resp_payload = w_status;
          w_status_clr   = 1'b1;
        end else begin
          w_frame_err = 1'b1;
        end
        w_next = w_resp_en ? ST_RESP : ST_IDLE;
      end
      ST_RESP: if (tx_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame <= '0;        r_slots <= '0;         r_result <= '0;
      r_result_valid <= 1'b0; r_busy <= 1'b0;      r_cop_start <= 1'b0;
      r_cnt <= '0;          r_err_frame <= 1'b0;   r_err_timeout <= 1'b0;
      r_err_busy <= 1'b0;   r_err_overrun <= 1'b0; r_drop_cnt <= '0;
      r_frame_cnt <= '0;    r_tx_valid <= 1'b0;    r_tx_data <= '0;
    end else begin
      if (r_state == ST_IDLE && frame_valid) begin
        r_frame     <= frame_data;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
      if (w_resp_en) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= {w_header, w_resp_payload, w_tx_trailer};
      end else if (r_tx_valid && tx_ready) begin
        r_tx_valid <= 1'b0;
      end
      for (int n = 0; n < NUM_SLOTS; n++) begin
        if (w_wr_en && w_slot_idx == 3'(n)) r_slots[n*PB +: PB] <= w_payload;
      end
      // Clears come first so that a flag raised in the same cycle survives
      if (w_status_clr) begin
        r_err_frame <= 1'b0; r_err_timeout <= 1'b0; r_err_busy <= 1'b0;
        r_err_overrun <= 1'b0; r_drop_cnt <= '0;
      end
      r_cop_start <= w_start_en;
      if (w_start_en) begin
        r_busy <= 1'b1; r_cnt <= '0; r_result_valid <= 1'b0;
      end else if (r_busy) begin
        if (cop_done) begin
          r_result <= cop_result; r_result_valid <= 1'b1; r_busy <= 1'b0;
        end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          r_err_timeout <= 1'b1; r_busy <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_frame_err) r_err_frame <= 1'b1;
      if (w_busy_err)  r_err_busy  <= 1'b1;
      if (w_drop) begin
        r_err_overrun <= 1'b1;
        r_drop_cnt    <= w_status_clr ? 8'd1 :
                         (r_drop_cnt == 8'hFF) ? 8'hFF : r_drop_cnt + 8'd1;
      end
    end
  end

  assign tx_valid  = r_tx_valid;
  assign tx_data   = r_tx_data;
  assign slots_out = r_slots;
  assign cop_start = r_cop_start;
  assign busy      = r_busy;
  assign err_any   = r_err_frame | r_err_timeout | r_err_busy | r_err_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_engine.sv
// ----------------------------------------------------------------------------
// tb_uart_cmd_engine: scoreboard bench for uart_cmd_engine (honours UART_CMD_CHECKSUM_EN)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_cmd_engine;

  localparam int P  = 16;
  localparam int PB = P * 8;
  localparam int FB = (P + 2) * 8;
`ifdef UART_CMD_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0, reset = 1'b1, frame_valid = 1'b0, tx_ready = 1'b0, cop_done = 1'b0;
  logic [FB-1:0] frame_data = '0;
  logic [PB-1:0] cop_result = '0;
  wire           tx_valid, cop_start, busy, err_any;
  wire  [FB-1:0] tx_data;
  wire  [2*PB-1:0] slots_out;

  uart_cmd_engine #(.PAYLOAD_BYTES(P), .NUM_SLOTS(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .frame_valid(frame_valid), .frame_data(frame_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .slots_out(slots_out),
    .cop_start(cop_start), .cop_done(cop_done), .cop_result(cop_result),
    .busy(busy), .err_any(err_any)
  );

  always #5 clk = ~clk;

  int            n_checks = 0, n_pass = 0;
  logic [FB-1:0] exp_q[$];
  logic [7:0]    exp_frame_cnt = 8'd0;
  logic [FB-1:0] got, exp;
  bit            ok;

  localparam logic [PB-1:0] KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [PB-1:0] TEXT = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [PB-1:0] RES  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [PB-1:0] PAT0 = 128'h000102030405060708090a0b0c0d0e0f;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] trl(input logic [7:0] h, input logic [PB-1:0] p);
    logic [7:0] x;
    x = h;
    if (CHK) for (int i = 0; i < P; i++) x = x ^ p[i*8 +: 8];
    return x;
  endfunction

  function automatic logic [FB-1:0] make_frame(input logic [7:0] h, input logic [PB-1:0] p);
    return {h, p, trl(h, p)};
  endfunction

  function automatic logic [FB-1:0] status_exp(input logic [7:0] b0, input logic [7:0] b1,
                                               input logic [7:0] b2);
    logic [PB-1:0] p;
    p = '0;
    p[PB-1 -: 8] = b0; p[PB-9 -: 8] = b1; p[PB-17 -: 8] = b2;
    return make_frame(8'h3F, p);
  endfunction

  // Drives one accepted frame; returns just after the sampling edge (DUT in DEC)
  task automatic send_frame(input logic [7:0] h, input logic [PB-1:0] p, input bit bad);
    frame_data = make_frame(h, p);
    if (bad) frame_data[7:0] = frame_data[7:0] ^ 8'h5A;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    exp_frame_cnt = exp_frame_cnt + 8'd1;
  endtask

  task automatic wait_tx(output logic [FB-1:0] data, output bit seen);
    seen = 1'b0; data = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (tx_valid) begin data = tx_data; seen = 1'b1; end
      else tick();
    end
    if (seen) begin tx_ready = 1'b1; tick(); tx_ready = 1'b0; end
  endtask

  task automatic test_reset();
    reset = 1'b1; repeat (3) tick(); reset = 1'b0; exp_frame_cnt = 8'd0;
    n_checks++;
    if ({tx_valid, cop_start, busy, err_any} !== 4'b0) $display("FAIL reset_ctrl: got %b expected 0000", {tx_valid, cop_start, busy, err_any}); else n_pass++;
    n_checks++;
    if (tx_data !== '0) $display("FAIL reset_tx_data: got %h expected 0", tx_data); else n_pass++;
    n_checks++;
    if (slots_out !== '0) $display("FAIL reset_slots: got %h expected 0", slots_out); else n_pass++;
    send_frame(8'h3F, '0, 1'b0);
    exp_q.push_back(status_exp(8'h00, 8'h00, exp_frame_cnt));
    wait_tx(got, ok); exp = exp_q.pop_front(); n_checks++;
    if (!ok) $display("FAIL reset_status: no response, expected %h", exp);
    else if (got !== exp) $display("FAIL reset_status: got %h expected %h", got, exp); else n_pass++;
  endtask

  task automatic test_write_read();
    send_frame(8'h70, PAT0, 1'b0);
    n_checks++;
    if (slots_out[PB-1:0] !== '0) $display("FAIL wr_latency_t1: got %h expected 0", slots_out[PB-1:0]); else n_pass++;
    tick();
    n_checks++;
    if (slots_out[PB-1:0] !== PAT0) $display("FAIL wr_slot0: got %h expected %h", slots_out[PB-1:0], PAT0); else n_pass++;
    n_checks++;
    if (tx_valid !== 1'b0) $display("FAIL wr_no_resp: got %b expected 0", tx_valid); else n_pass++;
    send_frame(8'h71, ~PAT0, 1'b0); tick();
    n_checks++;
    if (slots_out[2*PB-1:PB] !== ~PAT0) $display("FAIL wr_slot1: got %h expected %h", slots_out[2*PB-1:PB], ~PAT0); else n_pass++;
    for (int s = 0; s < 2; s++) begin
      send_frame(8'h50 + 8'(s), '0, 1'b0);
      exp_q.push_back(make_frame(8'h50 + 8'(s), (s == 0) ? PAT0 : ~PAT0));
      tick();
      n_checks++;
      if (tx_valid !== 1'b1) $display("FAIL rd_latency: got tx_valid %b expected 1", tx_valid); else n_pass++;
      wait_tx(got, ok); exp = exp_q.pop_front(); n_checks++;
      if (!ok) $display("FAIL rd_slot%0d: no response, expected %h", s, exp);
      else if (got !== exp) $display("FAIL rd_slot%0d: got %h expected %h", s, got, exp); else n_pass++;
    end
  endtask

  task automatic test_bad_frame();
    send_frame(8'h71, PAT0, 1'b1); tick();
    n_checks++;
    if (tx_valid !== 1'b0) $display("FAIL bad_no_resp: got %b expected 0", tx_valid); else n_pass++;
    n_checks++;
    if (slots_out[2*PB-1:PB] !== ~PAT0) $display("FAIL bad_slot_kept: got %h expected %h", slots_out[2*PB-1:PB], ~PAT0); else n_pass++;
    send_frame(8'h72, PAT0, 1'b0); tick();
    send_frame(8'h5A, PAT0, 1'b0); tick();
    n_checks++;
    if (err_any !== 1'b1) $display("FAIL bad_err_any: got %b expected 1", err_any); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      send_frame(8'h3F, '0, 1'b0);
      exp_q.push_back(status_exp((k == 0) ? 8'h02 : 8'h00, 8'h00, exp_frame_cnt));
      wait_tx(got, ok); exp = exp_q.pop_front(); n_checks++;
      if (!ok) $display("FAIL bad_status%0d: no response, expected %h", k, exp);
      else if (got !== exp) $display("FAIL bad_status%0d: got %h expected %h", k, got, exp); else n_pass++;
    end
  endtask

  task automatic test_run();
    send_frame(8'h70, KEY, 1'b0); tick();
    send_frame(8'h71, TEXT, 1'b0); tick();
    n_checks++;
    if (slots_out !== {TEXT, KEY}) $display("FAIL run_slots: got %h expected %h", slots_out, {TEXT, KEY}); else n_pass++;
    send_frame(8'h45, '0, 1'b0); tick();
    n_checks++;
    if ({cop_start, busy} !== 2'b11) $display("FAIL run_start: got %b expected 11", {cop_start, busy}); else n_pass++;
    send_frame(8'h45, '0, 1'b0);
    n_checks++;
    if (cop_start !== 1'b0) $display("FAIL run_start_pulse: got %b expected 0", cop_start); else n_pass++;
    tick();
    n_checks++;
    if ({cop_start, busy} !== 2'b01) $display("FAIL run_busy_restart: got %b expected 01", {cop_start, busy}); else n_pass++;
    repeat (8) tick();
    cop_done = 1'b1; cop_result = RES; tick(); cop_done = 1'b0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL run_done_busy: got %b expected 0", busy); else n_pass++;
    cop_done = 1'b1; cop_result = ~RES; tick(); cop_done = 1'b0;
    send_frame(8'h40, '0, 1'b0);
    exp_q.push_back(make_frame(8'h40, RES));
    wait_tx(got, ok); exp = exp_q.pop_front(); n_checks++;
    if (!ok) $display("FAIL run_result: no response, expected %h", exp);
    else if (got !== exp) $display("FAIL run_result: got %h expected %h", got, exp); else n_pass++;
    send_frame(8'h3F, '0, 1'b0);
    exp_q.push_back(status_exp(8'h09, 8'h00, exp_frame_cnt));
    wait_tx(got, ok); exp = exp_q.pop_front(); n_checks++;
    if (!ok) $display("FAIL run_status: no response, expected %h", exp);
    else if (got !== exp) $display("FAIL run_status: got %h expected %h", got, exp); else n_pass++;
  endtask

  task automatic test_timeout();
    int k;
    send_frame(8'h45, '0, 1'b0); tick();
    k = 0;
    while (busy && k < 40) begin tick(); k++; end
    n_checks++;
    if (k != 16) $display("FAIL timeout_len: got %0d cycles expected 16", k); else n_pass++;
    n_checks++;
    if (err_any !== 1'b1) $display("FAIL timeout_err_any: got %b expected 1", err_any); else n_pass++;
    send_frame(8'h3F, '0, 1'b0);
    exp_q.push_back(status_exp(8'h04, 8'h00, exp_frame_cnt));
    wait_tx(got, ok); exp = exp_q.pop_front(); n_checks++;
    if (!ok) $display("FAIL timeout_status: no response, expected %h", exp);
    else if (got !== exp) $display("FAIL timeout_status: got %h expected %h", got, exp); else n_pass++;
    // Done arriving on the last watchdog cycle must win over the timeout
    send_frame(8'h45, '0, 1'b0); tick();
    repeat (15) tick();
    cop_done = 1'b1; cop_result = ~RES; tick(); cop_done = 1'b0;
    n_checks++;
    if ({busy, err_any} !== 2'b00) $display("FAIL done_wins: got %b expected 00", {busy, err_any}); else n_pass++;
    send_frame(8'h40, '0, 1'b0);
    exp_q.push_back(make_frame(8'h40, ~RES));
    wait_tx(got, ok); exp = exp_q.pop_front(); n_checks++;
    if (!ok) $display("FAIL done_wins_result: no response, expected %h", exp);
    else if (got !== exp) $display("FAIL done_wins_result: got %h expected %h", got, exp); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [FB-1:0] held;
    bit stable;
    send_frame(8'h41, '0, 1'b0);
    exp_q.push_back(make_frame(8'h41, "1234567890123456"));
    tick();
    held = tx_data; stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      frame_valid = (i % 15 == 5);
      frame_data  = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
      tick();
      if (!tx_valid || tx_data !== held) stable = 1'b0;
    end
    frame_valid = 1'b0;
    n_checks++;
    if (!stable) $display("FAIL bp_stable: tx_data %h expected held %h", tx_data, held); else n_pass++;
    wait_tx(got, ok); exp = exp_q.pop_front(); n_checks++;
    if (!ok) $display("FAIL bp_ping: no response, expected %h", exp);
    else if (got !== exp) $display("FAIL bp_ping: got %h expected %h", got, exp); else n_pass++;
    send_frame(8'h3F, '0, 1'b0);
    exp_q.push_back(status_exp(8'h11, 8'd3, exp_frame_cnt));
    wait_tx(got, ok); exp = exp_q.pop_front(); n_checks++;
    if (!ok) $display("FAIL bp_status: no response, expected %h", exp);
    else if (got !== exp) $display("FAIL bp_status: got %h expected %h", got, exp); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    send_frame(8'h70, PAT0, 1'b1); tick();
    send_frame(8'h45, '0, 1'b0); tick();
    send_frame(8'h40, '0, 1'b0); tick();
    n_checks++;
    if ({tx_valid, busy, err_any} !== 3'b111) $display("FAIL rst_pre: got %b expected 111", {tx_valid, busy, err_any}); else n_pass++;
    reset = 1'b1; tick(); reset = 1'b0; exp_frame_cnt = 8'd0;
    n_checks++;
    if ({tx_valid, cop_start, busy, err_any} !== 4'b0 || tx_data !== '0 || slots_out !== '0)
      $display("FAIL rst_outputs: got ctrl %b tx %h slots %h expected all 0",
               {tx_valid, cop_start, busy, err_any}, tx_data, slots_out);
    else n_pass++;
    tick();
    cop_done = 1'b1; cop_result = RES; tick(); cop_done = 1'b0;
    send_frame(8'h3F, '0, 1'b0);
    exp_q.push_back(status_exp(8'h00, 8'h00, exp_frame_cnt));
    wait_tx(got, ok); exp = exp_q.pop_front(); n_checks++;
    if (!ok) $display("FAIL rst_status: no response, expected %h", exp);
    else if (got !== exp) $display("FAIL rst_status: got %h expected %h", got, exp); else n_pass++;
    send_frame(8'h40, '0, 1'b0);
    exp_q.push_back(make_frame(8'h40, '0));
    wait_tx(got, ok); exp = exp_q.pop_front(); n_checks++;
    if (!ok) $display("FAIL rst_result: no response, expected %h", exp);
    else if (got !== exp) $display("FAIL rst_result: got %h expected %h", got, exp); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "time limit");
  end

  initial begin
    tick();
    test_reset();
    test_write_read();
    test_bad_frame();
    test_run();
    test_timeout();
    test_backpressure();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
